if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the b-risc pipeline, directly upstream of the ID decoder. It owns the program counter and issues word-aligned requests to instruction memory over a valid/ready request channel. It absorbs in-order responses of arbitrary latency into a 2-entry instruction buffer and presents `{instr, pc}` to the decoder with a valid/ready handshake. Redirects (taken branches and jumps from later stages) flush the buffer and discard stale in-flight responses.

## Interface
- `INSTR_W`, default `` `INSTR_W `` (32): instruction width.
- `WORD_W`, default `` `WORD_W `` (32): PC / address width.
- `RESET_PC`, default 0: PC loaded on reset.
- `BUF_DEPTH`, default 2: instruction buffer entries, and the cap on outstanding requests plus buffered instructions.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  WORD_W  fetch address; always 4-byte aligned.
- `imem_resp_valid`  in  1  response valid; in request order; always accepted.
- `imem_resp_data`  in  INSTR_W  fetched instruction.
- `redirect_valid`  in  1  redirect fetch to `redirect_pc`.
- `redirect_pc`  in  WORD_W  target; bits [1:0] ignored (forced 0).
- `id_valid`  out  1  `id_instr`/`id_pc` valid for decoder.
- `id_ready`  in  1  decoder accepts (deassert = stall).
- `id_instr`  out  INSTR_W  instruction to decoder.
- `id_pc`  out  WORD_W  PC of `id_instr`.

## Operation
- Registers: `pc`, `outstanding` (0..BUF_DEPTH), `drop_cnt` (0..BUF_DEPTH), buffer count, FSM state.
- FSM states:
  - `S_BOOT`: first cycle after reset; no request. Goes to `S_RUN`.
  - `S_RUN`: normal fetching.
  - `S_FLUSH`: stale responses are pending. No requests are issued. Goes to `S_RUN` once `drop_cnt` reaches 0, including on the cycle the last stale response arrives.
- Request issue: `imem_req_valid` = `S_RUN` && !`redirect_valid` && (`outstanding` + count − pop < BUF_DEPTH), where pop = `id_valid && id_ready`. `imem_req_addr` = `pc`.
- On request handshake: `pc` ← `pc` + 4, modulo 2^WORD_W (0xFFFFFFFC wraps to 0). `outstanding` increments.
- Response in `S_RUN`: push `{data, pc_of_req}` into the buffer and decrement `outstanding`. The request PC travels in a parallel PC queue. Credit rule guarantees no overflow.
- Response in `S_FLUSH`: discard it and decrement `drop_cnt`.
- Decoder side: `id_valid` = buffer non-empty; head entry is driven on `id_instr`/`id_pc`. Entry is popped on `id_valid && id_ready`. Outputs hold stable while stalled.
- Redirect has priority over every other same-cycle event:
  - `pc` ← `{redirect_pc[WORD_W-1:2], 2'b00}`.
  - Buffer cleared.
  - `drop_cnt` ← `outstanding` − (response this cycle ? 1 : 0). A response arriving the same cycle is discarded.
  - A same-cycle pop is irrelevant.
  - `outstanding` ← 0.
  - State ← `S_FLUSH` if the new `drop_cnt` > 0, else `S_RUN`.
- A redirect while in `S_FLUSH` adds nothing; `drop_cnt` only decrements as stale responses arrive.
- `rst` mid-operation: all state returns to reset values; responses from pre-reset requests are the memory's responsibility to squash.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `id_valid`=0, `id_instr`=0, `id_pc`=0, `pc`=RESET_PC, counters 0, state `S_BOOT`.
- First request: cycle 1 after `rst` deasserts.
- Latency: request accepted at T, response at T+k (k≥1), `id_valid` at T+k+1 (buffer is registered).
- Throughput: with k=1 and `id_ready` held high, 1 instruction/cycle is sustained with BUF_DEPTH=2.
- Redirect at cycle R with nothing outstanding: request to the target at R+1, `id_valid` no earlier than R+3. `id_valid`=0 at R+1.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - Adds `perf_fetch_cnt` out WORD_W: count of instructions delivered to ID.
  - Adds `perf_stall_cnt` out WORD_W: count of cycles with `id_valid && !id_ready`.
  - Adds `perf_flush_cnt` out WORD_W: count of redirects.
  - All three reset to 0 and wrap modulo 2^WORD_W.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

## Structure
- Shared header `if_defs.vh`: FSM state encodings (`IF_S_BOOT`, `IF_S_RUN`, `IF_S_FLUSH`), `IF_STATE_W`, `PC_INC` (=4). `INSTR_W`/`WORD_W` continue to come from `config.vh`.
- Sub-module `if_instr_buf`: parameterised synchronous FIFO of `{pc, instr}` with push, pop, clear, and count. Clear has priority over push.

## Test plan
- Reset release, memory k=1, `id_ready`=1 → requests 0x0, 0x4, 0x8 … on consecutive cycles; `id_valid` first at cycle 3 with `id_pc`=0x0; one instruction per cycle thereafter.
- `id_ready`=0 for 5 cycles → at most 2 outstanding+buffered, `imem_req_valid` drops, `id_instr`/`id_pc` held; release → PC sequence continues with no loss or duplicate.
- Memory k=3, 2 requests outstanding, redirect to 0x103 → `pc`=0x100, two responses dropped, first `id_pc` after the redirect is 0x100.
- Redirect on the same cycle as a response and a pop → that response is dropped, buffer empty next cycle, no stale `id_valid`.
- RESET_PC=0xFFFFFFF8 → fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- With `IF_PERF_CNT_EN`: 10 delivered, 3 stall cycles, 1 redirect → counters read 10/3/1.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and FSM encoding for the b-risc instruction-fetch stage.
`ifndef INSTR_W
`define INSTR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif

package if_fetch_stage_pkg;
    localparam int INSTR_W_DEF = `INSTR_W;
    localparam int WORD_W_DEF  = `WORD_W;
    localparam int IF_STATE_W  = 2;
    localparam int PC_INC      = 4;

    typedef enum logic [IF_STATE_W-1:0] {
        IF_S_BOOT  = 2'd0,
        IF_S_RUN   = 2'd1,
        IF_S_FLUSH = 2'd2
    } if_state_e;
endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: imem request/response, redirect input and the ID-side handshake.
interface if_fetch_stage_if
    import if_fetch_stage_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int WORD_W  = WORD_W_DEF
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [WORD_W-1:0]  imem_req_addr;
    logic               imem_resp_valid;
    logic [INSTR_W-1:0] imem_resp_data;
    logic               redirect_valid;
    logic [WORD_W-1:0]  redirect_pc;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [WORD_W-1:0]  id_pc;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_instr_buf.sv
// Small synchronous FIFO with head peek and occupancy count; clear wins over push.
module if_instr_buf #(
    parameter int DW    = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_clear,
    input  logic [DW-1:0]                i_data,
    output logic [DW-1:0]                o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][DW-1:0] r_mem;
    logic [PW-1:0]            r_rd, r_wr;
    logic [CW-1:0]            r_count;
    logic                     w_do_pop, w_do_push;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);
    assign o_head    = r_mem[r_rd];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem   <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= nxt(r_wr);
            end
            if (w_do_pop)
                r_rd <= nxt(r_rd);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// b-risc instruction fetch: PC, credit-limited imem requests, 2-entry buffer, redirect flush.
// Optional IF_PERF_CNT_EN adds fetch/stall/flush performance counters.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                INSTR_W   = INSTR_W_DEF,
    parameter int                WORD_W    = WORD_W_DEF,
    parameter logic [WORD_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [WORD_W-1:0] perf_fetch_cnt,
    output logic [WORD_W-1:0] perf_stall_cnt,
    output logic [WORD_W-1:0] perf_flush_cnt
`endif
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    if_state_e                 r_state;
    logic [WORD_W-1:0]         r_pc;
    logic [CW-1:0]             r_drop_cnt;
    logic [CW-1:0]             w_outstanding, w_buf_cnt;
    logic [CW-1:0]             w_flush_left, w_redir_left;
    logic [WORD_W-1:0]         w_req_pc;
    logic [WORD_W+INSTR_W-1:0] w_head;
    logic                      w_pop, w_req_fire, w_resp, w_resp_run, w_redirect;

    assign w_redirect = bus.redirect_valid;
    assign w_resp     = bus.imem_resp_valid;
    assign w_pop      = bus.id_valid && bus.id_ready;
    assign w_req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign w_resp_run = w_resp && (r_state == IF_S_RUN) && !w_redirect;

    // Stale responses still owed after this cycle, in flush and on a fresh redirect.
    assign w_flush_left = (w_resp && r_drop_cnt != '0) ? r_drop_cnt - CW'(1) : r_drop_cnt;
    assign w_redir_left = (w_resp && w_outstanding != '0) ? w_outstanding - CW'(1) : w_outstanding;

    always_comb begin
        bus.imem_req_valid = 1'b0;
        if (r_state == IF_S_RUN && !w_redirect)
            bus.imem_req_valid = (int'(w_outstanding) + int'(w_buf_cnt) - int'(w_pop)) < BUF_DEPTH;
    end

    assign bus.imem_req_addr         = r_pc;
    assign bus.id_valid              = (w_buf_cnt != '0);
    assign {bus.id_pc, bus.id_instr} = w_head;

    // PC queue: its occupancy is the outstanding-request count.
    if_instr_buf #(.DW(WORD_W), .DEPTH(BUF_DEPTH)) u_pcq (
        .clk(clk), .rst(rst),
        .i_push(w_req_fire), .i_pop(w_resp_run), .i_clear(w_redirect),
        .i_data(r_pc), .o_head(w_req_pc), .o_count(w_outstanding)
    );

    if_instr_buf #(.DW(WORD_W + INSTR_W), .DEPTH(BUF_DEPTH)) u_ibuf (
        .clk(clk), .rst(rst),
        .i_push(w_resp_run), .i_pop(w_pop), .i_clear(w_redirect),
        .i_data({w_req_pc, bus.imem_resp_data}), .o_head(w_head), .o_count(w_buf_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IF_S_BOOT;
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            if (w_redirect)
                r_pc <= bus.redirect_pc & ~WORD_W'(3);
            else if (w_req_fire)
                r_pc <= r_pc + WORD_W'(PC_INC);
            case (r_state)
                IF_S_BOOT, IF_S_RUN: begin
                    if (w_redirect) begin
                        r_drop_cnt <= w_redir_left;
                        r_state    <= (w_redir_left != '0) ? IF_S_FLUSH : IF_S_RUN;
                    end else begin
                        r_state <= IF_S_RUN;
                    end
                end
                IF_S_FLUSH: begin
                    r_drop_cnt <= w_flush_left;
                    if (w_flush_left == '0)
                        r_state <= IF_S_RUN;
                end
                default: r_state <= IF_S_BOOT;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (w_pop)
                perf_fetch_cnt <= perf_fetch_cnt + WORD_W'(1);
            if (bus.id_valid && !bus.id_ready)
                perf_stall_cnt <= perf_stall_cnt + WORD_W'(1);
            if (w_redirect)
                perf_flush_cnt <= perf_flush_cnt + WORD_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: in-order random-latency memory plus a queue-level reference model.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_stage_if #(.INSTR_W(32), .WORD_W(32)) bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] pf_fetch, pf_stall, pf_flush;
`endif

    if_fetch_stage #(.INSTR_W(32), .WORD_W(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(pf_fetch), .perf_stall_cnt(pf_stall), .perf_flush_cnt(pf_flush)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mq[$];      // memory: accepted requests awaiting response
    logic [31:0] mbuf[$];    // PCs the decoder should see, oldest first
    logic [31:0] exp_req;    // next PC the stage should request
    int cyc, last_due, n_chk, n_pass;
    int rdy_pct, idr_pct, lat_lo, lat_hi, redir_pm, dir_redir_cyc;
    int n_pops, n_stalls, n_redirs;
    logic [31:0] dir_redir_tgt;
    bit          log_rv[64], log_iv[64];
    logic [31:0] log_ra[64], log_ipc[64];

    function automatic logic [31:0] f(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic set_mode(input int rdy, input int idr, input int lo, input int hi, input int pm);
        rdy_pct = rdy; idr_pct = idr; lat_lo = lo; lat_hi = hi; redir_pm = pm;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = '0;
        bus.redirect_valid = 0; bus.redirect_pc = '0; bus.id_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_id_instr", bus.id_instr, 32'h0);
        chk("rst_id_pc", bus.id_pc, 32'h0);
        mq.delete(); mbuf.delete();
        exp_req = 32'h0; last_due = -1; cyc = 0;
        n_pops = 0; n_stalls = 0; n_redirs = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic cycle();
        bit redir, rsp, rdy, idr, rv, iv, stale_any, mpop, exp_rv;
        logic [31:0] tgt, ra, ipc, iin;
        int fresh, due;
        mreq_t h, e;
        rdy   = ($urandom_range(99) < rdy_pct);
        idr   = ($urandom_range(99) < idr_pct);
        redir = (cyc == dir_redir_cyc) || ($urandom_range(999) < redir_pm);
        tgt   = (cyc == dir_redir_cyc) ? dir_redir_tgt : $urandom;
        rsp   = (mq.size() > 0) && (mq[0].due <= cyc);
        bus.imem_req_ready  = rdy;
        bus.id_ready        = idr;
        bus.redirect_valid  = redir;
        bus.redirect_pc     = tgt;
        bus.imem_resp_valid = rsp;
        bus.imem_resp_data  = rsp ? f(mq[0].addr) : $urandom;
        @(negedge clk);
        rv = bus.imem_req_valid; ra = bus.imem_req_addr;
        iv = bus.id_valid; ipc = bus.id_pc; iin = bus.id_instr;
        stale_any = 0; fresh = 0;
        foreach (mq[i]) if (mq[i].stale) stale_any = 1; else fresh++;
        mpop   = (mbuf.size() > 0) && idr;
        exp_rv = (cyc != 0) && !redir && !stale_any && (fresh + mbuf.size() - (mpop ? 1 : 0) < 2);
        chk("req_valid", 32'(rv), 32'(exp_rv));
        chk("req_addr", ra, exp_req);
        chk("id_valid", 32'(iv), 32'(mbuf.size() > 0));
        if (mbuf.size() > 0) begin
            chk("id_pc", ipc, mbuf[0]);
            chk("id_instr", iin, f(mbuf[0]));
        end
        if (cyc < 64) begin
            log_rv[cyc] = rv; log_ra[cyc] = ra; log_iv[cyc] = iv; log_ipc[cyc] = ipc;
        end
        if (iv && idr) n_pops++;
        if (iv && !idr) n_stalls++;
        if (redir) n_redirs++;
        if (rsp) h = mq.pop_front();
        if (redir) begin
            foreach (mq[i]) begin e = mq[i]; e.stale = 1; mq[i] = e; end
            mbuf.delete();
            exp_req = tgt & ~32'h3;
        end else begin
            if (mpop) void'(mbuf.pop_front());
            if (rsp && !h.stale) mbuf.push_back(h.addr);
            if (rv && rdy) begin
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                e.addr = exp_req; e.due = due; e.stale = 0;
                mq.push_back(e);
                exp_req = exp_req + 32'd4;
            end
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; dir_redir_cyc = -1; dir_redir_tgt = '0;

        // Steady streaming with k=1, then a 5-cycle decoder stall.
        set_mode(100, 100, 1, 1, 0);
        do_reset();
        repeat (12) cycle();
        idr_pct = 0;
        repeat (5) cycle();
        idr_pct = 100;
        repeat (10) cycle();
        chk("t1_rv0", 32'(log_rv[0]), 32'd0);
        chk("t1_rv1", 32'(log_rv[1]), 32'd1);
        chk("t1_ra1", log_ra[1], 32'h0);
        chk("t1_ra2", log_ra[2], 32'h4);
        chk("t1_ra3", log_ra[3], 32'h8);
        chk("t1_iv2", 32'(log_iv[2]), 32'd0);
        chk("t1_ipc3", log_ipc[3], 32'h0);
        chk("t1_ipc4", log_ipc[4], 32'h4);
        chk("t1_ipc10", log_ipc[10], 32'h1C);
        for (int c = 3; c < 12; c++) chk("t1_stream_iv", 32'(log_iv[c]), 32'd1);
        for (int c = 12; c < 17; c++) begin
            chk("t2_hold_iv", 32'(log_iv[c]), 32'd1);
            chk("t2_hold_pc", log_ipc[c], 32'h24);
            chk("t2_stall_rv", 32'(log_rv[c]), 32'd0);
        end
        chk("t2_ra17", log_ra[17], 32'h2C);
        chk("t2_ipc18", log_ipc[18], 32'h28);

        // k=3, two outstanding, redirect to an unaligned target.
        set_mode(100, 100, 3, 3, 0);
        dir_redir_cyc = 3; dir_redir_tgt = 32'h103;
        do_reset();
        repeat (14) cycle();
        chk("t3_rv3", 32'(log_rv[3]), 32'd0);
        chk("t3_ra4", log_ra[4], 32'h100);
        chk("t3_rv5", 32'(log_rv[5]), 32'd0);
        chk("t3_rv6", 32'(log_rv[6]), 32'd1);
        chk("t3_ra6", log_ra[6], 32'h100);
        for (int c = 4; c < 10; c++) chk("t3_no_stale_iv", 32'(log_iv[c]), 32'd0);
        chk("t3_iv10", 32'(log_iv[10]), 32'd1);
        chk("t3_ipc10", log_ipc[10], 32'h100);

        // Redirect coinciding with a response and a pop.
        set_mode(100, 100, 1, 1, 0);
        dir_redir_cyc = 5; dir_redir_tgt = 32'h200;
        do_reset();
        repeat (12) cycle();
        chk("t4_iv5", 32'(log_iv[5]), 32'd1);
        chk("t4_ipc5", log_ipc[5], 32'h8);
        chk("t4_iv6", 32'(log_iv[6]), 32'd0);
        chk("t4_ra6", log_ra[6], 32'h200);
        chk("t4_iv7", 32'(log_iv[7]), 32'd0);
        chk("t4_ipc8", log_ipc[8], 32'h200);

        // PC wrap at the top of the address space.
        dir_redir_cyc = 2; dir_redir_tgt = 32'hFFFF_FFF9;
        do_reset();
        repeat (10) cycle();
        chk("t5_ra3", log_ra[3], 32'hFFFF_FFF8);
        chk("t5_ra4", log_ra[4], 32'hFFFF_FFFC);
        chk("t5_ra5", log_ra[5], 32'h0);
        chk("t5_ipc5", log_ipc[5], 32'hFFFF_FFF8);
        chk("t5_ipc7", log_ipc[7], 32'h0);

        // Randomised traffic, latencies and redirects.
        dir_redir_cyc = -1;
        set_mode(70, 70, 1, 4, 30);
        do_reset();
        repeat (3000) cycle();
        set_mode(50, 30, 1, 3, 120);
        do_reset();
        repeat (2000) cycle();
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", pf_fetch, 32'(n_pops));
        chk("perf_stall", pf_stall, 32'(n_stalls));
        chk("perf_flush", pf_flush, 32'(n_redirs));
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
